ex_div: RTL
===========

# ex_div

Iterative 32-bit integer divider living in the EX stage, fed by operands and control held in the dispatch→EX pipeline register. A divide instruction arriving in EX starts a radix-2 restoring division. The divider raises a pause request so the pipeline control freezes the EX-input register until the result is ready. It returns quotient and remainder for signed or unsigned operands, with one-cycle completion for divide-by-zero.

## Interface
- `DATA_WIDTH`, 32: operand and result width; iteration count equals `DATA_WIDTH`.
- `clk`  in  1  — single clock; all state updates on rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `flush`  in  1  — exception flush from pipeline control; synchronous abort.
- `start`  in  1  — EX holds a valid divide/modulo instruction.
- `is_signed`  in  1  — 1: two's-complement operands; 0: unsigned.
- `dividend`  in  DATA_WIDTH  — numerator from the EX-input register.
- `divisor`  in  DATA_WIDTH  — denominator from the EX-input register.
- `quotient`  out  DATA_WIDTH  — result quotient; valid while `done`.
- `remainder`  out  DATA_WIDTH  — result remainder; valid while `done`.
- `done`  out  1  — result valid; high exactly one cycle per completed operation.
- `busy`  out  1  — state is not IDLE.
- `pause_req`  out  1  — stall request to pipeline control (combinational).

## Operation
- States: IDLE, CALC, DONE.
- **IDLE** + `start` + !`flush`:
  - latch the absolute values of the operands (absolute only when `is_signed`);
  - latch the quotient-negate flag: `is_signed` & sign(dividend)≠sign(divisor);
  - latch the remainder-negate flag: `is_signed` & sign(dividend);
  - divisor==0 → DONE; else → CALC with iteration counter=0 and partial remainder=0.
- **CALC**, one restoring step per cycle:
  - shift {partial remainder, dividend} left 1;
  - trial-subtract the divisor using a DATA_WIDTH+1-bit subtractor;
  - on non-negative difference, keep it and set quotient bit 1; else restore and set quotient bit 0;
  - counter increments each step; after step DATA_WIDTH-1 → DONE.
- **DONE**: `done`=1 for one cycle, then → IDLE unconditionally. `start` is ignored in DONE, because it still reflects the instruction being retired that edge.
- Sign fix-up is applied when entering DONE: negate the quotient if its flag is set; negate the remainder if its flag is set.
- Divide by zero: quotient = all ones (0xFFFFFFFF); remainder = original dividend unmodified. Applies to both signed and unsigned.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0. This falls out of the unsigned-magnitude path with no special case.
- Operand inputs are ignored after latching; changes during CALC have no effect.
- `quotient`/`remainder` hold their last value until the next completion.
- `pause_req` = (IDLE & `start`) | CALC. It is low in DONE, so the EX-input register advances on the DONE edge.
- `flush` has priority over everything except `rst`: any state → IDLE next edge; no `done` is produced; result registers are unchanged.
- `rst`: state IDLE, counter 0, `quotient`=0, `remainder`=0, `done`=0, `busy`=0. `pause_req`=0 unless `start` is asserted.

## Timing
- Cycle 0 = cycle in which `start` is sampled high in IDLE.
- Normal division: CALC occupies cycles 1..32; `done` is high in cycle 33; total latency 33 cycles.
- Divide by zero: `done` is high in cycle 1.
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- `pause_req` is high from cycle 0 through the last CALC cycle.
- Back-to-back operations: a new `start` is accepted in the IDLE cycle immediately after DONE, i.e. at best one idle cycle between results.
- `flush` asserted in cycle N of CALC: IDLE in cycle N+1, `busy`=0, `done` never rises.
- `rst` asserted mid-operation: outputs reach reset values immediately, without waiting for a clock edge.

## Test plan
- Unsigned 100 / 7, `start` at cycle 0 → `done` only in cycle 33; `quotient`=14, `remainder`=2; `pause_req` high in cycles 0–32.
- Signed 0xFFFFFFF9 (−7) / 2 → `quotient`=0xFFFFFFFD (−3), `remainder`=0xFFFFFFFF (−1).
- Unsigned 0xFFFFFFF9 / 2 → `quotient`=0x7FFFFFFC, `remainder`=1.
- 0x12345678 / 0, signed and unsigned → `done` in cycle 1; `quotient`=0xFFFFFFFF, `remainder`=0x12345678; `pause_req` low in cycle 1.
- Signed 0x80000000 / 0xFFFFFFFF → `quotient`=0x80000000, `remainder`=0. Then a back-to-back signed 9 / −4 started in the IDLE cycle → `quotient`=0xFFFFFFFE, `remainder`=1.
- `flush` in cycle 10 of CALC → `busy`=0 in cycle 11, no `done`, previous results held. Then async `rst` pulse mid-CALC of a new operation → outputs zero immediately; a following 100 / 7 completes correctly.

Source files
------------

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for the EX stage: signed/unsigned
// quotient and remainder in DATA_WIDTH cycles, single-cycle divide-by-zero.
module ex_div #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  done,
  output logic                  busy,
  output logic                  pause_req
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [DW-1:0] rem_r, dvd_r, dsr_r, q_r, r_r;
  logic          neg_q, neg_r;

  logic [DW-1:0] a_abs, b_abs, rem_step, quo_step;
  logic [DW:0]   sh, diff;
  logic          qbit, last, div_zero;

  assign a_abs    = (is_signed && dividend[DW-1]) ? -dividend : dividend;
  assign b_abs    = (is_signed && divisor[DW-1])  ? -divisor  : divisor;
  assign div_zero = (divisor == '0);
  assign last     = (cnt == CW'(DW - 1));

  // Partial remainder can briefly need DW+1 bits after the shift.
  assign sh       = {rem_r, dvd_r[DW-1]};
  assign diff     = sh - {1'b0, dsr_r};
  assign qbit     = ~diff[DW];
  assign rem_step = qbit ? diff[DW-1:0] : sh[DW-1:0];
  assign quo_step = {dvd_r[DW-2:0], qbit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = div_zero ? DONE : CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      rem_r <= '0;
      dvd_r <= '0;
      dsr_r <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      q_r   <= '0;
      r_r   <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: if (start) begin
          dvd_r <= a_abs;
          dsr_r <= b_abs;
          rem_r <= '0;
          cnt   <= '0;
          neg_q <= is_signed & (dividend[DW-1] ^ divisor[DW-1]);
          neg_r <= is_signed & dividend[DW-1];
          if (div_zero) begin
            q_r <= '1;
            r_r <= dividend;
          end
        end
        CALC: begin
          rem_r <= rem_step;
          dvd_r <= quo_step;
          cnt   <= cnt + CW'(1);
          // Sign fix-up lands together with the final step.
          if (last) begin
            q_r <= neg_q ? -quo_step : quo_step;
            r_r <= neg_r ? -rem_step : rem_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient  = q_r;
  assign remainder = r_r;
  assign done      = (state == DONE);
  assign busy      = (state != IDLE);
  assign pause_req = ((state == IDLE) && start) || (state == CALC);
endmodule
